// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: clock inhibit, request-to-send, 11-bit frame
// clocked out by the device, and ACK check. Reports the outcome with one-cycle pulses.
module ps2_command_tx #(
    parameter int unsigned INHIBIT_CYCLES       = 5000,
    parameter int unsigned START_TIMEOUT_CYCLES = 750000,
    parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       send,
    input  logic [7:0] command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_low,
    output logic       ps2_dat_low,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam logic [19:0] INHIBIT_LOAD = 20'(INHIBIT_CYCLES);
    localparam logic [19:0] START_LOAD   = 20'(START_TIMEOUT_CYCLES);
    localparam logic [19:0] XFER_LOAD    = 20'(XFER_TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRequest,
        StWaitClk,
        StXfer,
        StWaitIdle,
        StDone,
        StError
    } state_t;

    state_t      state;
    logic        clk_meta, clk_sync, clk_sync_prev;
    logic        dat_meta, dat_sync;
    logic [9:0]  shift;
    logic [3:0]  count;
    logic [19:0] timer;
    logic        clk_fall;
    logic        timer_expired;

    assign clk_fall      = clk_sync_prev & ~clk_sync;
    // The timer is loaded with N and expires on the cycle it would step from 1 to 0.
    assign timer_expired = (timer <= 20'd1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_meta      <= 1'b1;
            clk_sync      <= 1'b1;
            clk_sync_prev <= 1'b1;
            dat_meta      <= 1'b1;
            dat_sync      <= 1'b1;
        end else begin
            clk_meta      <= ps2_clk_in;
            clk_sync      <= clk_meta;
            clk_sync_prev <= clk_sync;
            dat_meta      <= ps2_dat_in;
            dat_sync      <= dat_meta;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= StIdle;
            shift       <= '0;
            count       <= '0;
            timer       <= '0;
            ps2_clk_low <= 1'b0;
            ps2_dat_low <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            unique case (state)
                StIdle: begin
                    ps2_clk_low <= 1'b0;
                    ps2_dat_low <= 1'b0;
                    busy        <= 1'b0;
                    if (send) begin
                        shift       <= {1'b1, ~^command, command};
                        count       <= '0;
                        timer       <= INHIBIT_LOAD;
                        ps2_clk_low <= 1'b1;
                        busy        <= 1'b1;
                        state       <= StInhibit;
                    end
                end
                StInhibit: begin
                    if (timer_expired) begin
                        ps2_dat_low <= 1'b1;
                        state       <= StRequest;
                    end else begin
                        timer <= timer - 20'd1;
                    end
                end
                StRequest: begin
                    // Start bit is already on the wire when the clock is released.
                    ps2_clk_low <= 1'b0;
                    timer       <= START_LOAD;
                    state       <= StWaitClk;
                end
                StWaitClk: begin
                    if (timer_expired) begin
                        ps2_dat_low <= 1'b0;
                        tx_error    <= 1'b1;
                        timer       <= '0;
                        state       <= StError;
                    end else if (clk_fall) begin
                        ps2_dat_low <= ~shift[0];
                        shift       <= {1'b1, shift[9:1]};
                        count       <= 4'd1;
                        timer       <= XFER_LOAD;
                        state       <= StXfer;
                    end else begin
                        timer <= timer - 20'd1;
                    end
                end
                StXfer: begin
                    if (timer_expired) begin
                        ps2_dat_low <= 1'b0;
                        tx_error    <= 1'b1;
                        timer       <= '0;
                        state       <= StError;
                    end else begin
                        timer <= timer - 20'd1;
                        if (clk_fall) begin
                            if (count == 4'd10) begin
                                ps2_dat_low <= 1'b0;
                                if (!dat_sync) begin
                                    state <= StWaitIdle;
                                end else begin
                                    tx_error <= 1'b1;
                                    state    <= StError;
                                end
                            end else begin
                                ps2_dat_low <= ~shift[0];
                                shift       <= {1'b1, shift[9:1]};
                                count       <= count + 4'd1;
                            end
                        end
                    end
                end
                StWaitIdle: begin
                    if (timer_expired) begin
                        tx_error <= 1'b1;
                        timer    <= '0;
                        state    <= StError;
                    end else begin
                        timer <= timer - 20'd1;
                        if (clk_sync && dat_sync) begin
                            tx_done <= 1'b1;
                            state   <= StDone;
                        end
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                StError: begin
                    ps2_clk_low <= 1'b0;
                    ps2_dat_low <= 1'b0;
                    busy        <= 1'b0;
                    state       <= StIdle;
                end
                default: begin
                    ps2_clk_low <= 1'b0;
                    ps2_dat_low <= 1'b0;
                    busy        <= 1'b0;
                    state       <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Bench for ps2_command_tx: behavioural PS/2 device, frame reference model and a
// scoreboard that matches every done/error pulse against the queued expectation.
module tb_ps2_command_tx;

    localparam int unsigned INHIBIT = 10;
    localparam int unsigned START_TO = 200;
    localparam int unsigned XFER_TO = 2000;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       send = 1'b0;
    logic [7:0] command = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       clk_line, dat_line;
    logic       ps2_clk_low, ps2_dat_low, busy, tx_done, tx_error;

    // Open-drain wired-AND of host and device drivers.
    assign clk_line = dev_clk & ~ps2_clk_low;
    assign dat_line = dev_dat & ~ps2_dat_low;

    ps2_command_tx #(
        .INHIBIT_CYCLES       (INHIBIT),
        .START_TIMEOUT_CYCLES (START_TO),
        .XFER_TIMEOUT_CYCLES  (XFER_TO)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .send        (send),
        .command     (command),
        .ps2_clk_in  (clk_line),
        .ps2_dat_in  (dat_line),
        .ps2_clk_low (ps2_clk_low),
        .ps2_dat_low (ps2_dat_low),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_err;
        logic        has_frame;
        logic [10:0] frame;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] cap_q[$];
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Line values seen by the device before each of its 11 falling edges:
    // start, data LSB-first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] c);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = c[i];
        f[9]  = ($countones(c) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic expect_result(input logic [7:0] c, input logic is_err, input logic has_frame);
        exp_t e;
        e.is_err    = is_err;
        e.has_frame = has_frame;
        e.frame     = model_frame(c);
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (resetn && (tx_done || tx_error)) begin
            exp_t e;
            check("pulse_exclusive", 32'(tx_done & tx_error), 0);
            check("pins_released_at_pulse", 32'({ps2_clk_low, ps2_dat_low}), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'({tx_done, tx_error}), 0);
            end else begin
                e = exp_q.pop_front();
                check("outcome_is_error", 32'(tx_error), 32'(e.is_err));
                if (e.has_frame) begin
                    if (cap_q.size() == 0) check("frame_captured", 0, 1);
                    else check("frame_bits", 32'(cap_q.pop_front()), 32'(e.frame));
                end
            end
        end
    end

    // Send one command; checks acceptance latency and clock-inhibit length.
    task automatic issue(input logic [7:0] c);
        int n_low = 0;
        int n_req = 0;
        send = 1'b1;
        command = c;
        @(negedge clock);
        send = 1'b0;
        command = 8'($urandom);
        check("accept_busy", 32'(busy), 1);
        check("accept_clk_low", 32'(ps2_clk_low), 1);
        while (ps2_clk_low && n_low < 1000) begin
            n_low++;
            if (ps2_dat_low) n_req++;
            @(negedge clock);
        end
        check("inhibit_len", n_low, INHIBIT + 1);
        check("request_len", n_req, 1);
        check("start_bit_held", 32'(ps2_dat_low), 1);
    endtask

    // Device: 11 clock pulses, ACK low on the 11th if ack; abort_at>=0 resets the DUT instead.
    task automatic device_run(input logic ack, input int abort_at);
        logic [10:0] bits;
        bits = '0;
        repeat (30) @(negedge clock);
        for (int i = 0; i < 11; i++) begin
            if (i == abort_at) begin
                check("busy_before_reset", 32'(busy), 1);
                resetn = 1'b0;
                #1;
                check("reset_pins_released", 32'({ps2_clk_low, ps2_dat_low}), 0);
                check("reset_busy", 32'(busy), 0);
                check("reset_no_pulse", 32'({tx_done, tx_error}), 0);
                @(negedge clock);
                @(negedge clock);
                resetn = 1'b1;
                return;
            end
            bits[i] = dat_line;
            if (i == 10) cap_q.push_back(bits);
            dev_clk = 1'b0;
            if (i == 10 && ack) dev_dat = 1'b0;
            repeat (20) @(negedge clock);
            dev_clk = 1'b1;
            dev_dat = 1'b1;
            repeat (20) @(negedge clock);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clock);
        end
        check("returns_idle", 32'(busy), 0);
        repeat (5) @(negedge clock);
    endtask

    task automatic run_no_clock(input logic [7:0] c);
        int n = 0;
        expect_result(c, 1'b1, 1'b0);
        issue(c);
        while (!tx_error && n < 1000) begin
            n++;
            @(negedge clock);
        end
        check("start_timeout_cycles", n, START_TO);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] c;
        int         sc;
        repeat (3) @(negedge clock);
        check("rst_outputs", 32'({ps2_clk_low, ps2_dat_low, busy, tx_done, tx_error}), 0);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_outputs", 32'({ps2_clk_low, ps2_dat_low, busy}), 0);

        expect_result(8'hED, 1'b0, 1'b1);
        issue(8'hED);
        device_run(1'b1, -1);
        wait_idle();

        expect_result(8'hF4, 1'b0, 1'b1);
        issue(8'hF4);
        device_run(1'b1, -1);
        wait_idle();

        run_no_clock(8'hED);

        expect_result(8'h3C, 1'b1, 1'b1);
        issue(8'h3C);
        device_run(1'b0, -1);
        wait_idle();

        // A send during the transfer must be ignored.
        expect_result(8'hED, 1'b0, 1'b1);
        issue(8'hED);
        fork
            device_run(1'b1, -1);
            begin
                repeat (100) @(negedge clock);
                send = 1'b1;
                command = 8'h00;
                @(negedge clock);
                send = 1'b0;
            end
        join
        wait_idle();

        issue(8'hA5);
        device_run(1'b1, 5);
        repeat (3) @(negedge clock);
        check("after_reset_idle", 32'({ps2_clk_low, ps2_dat_low, busy}), 0);

        for (int k = 0; k < 10; k++) begin
            c  = 8'($urandom);
            sc = int'($urandom_range(0, 2));
            if (sc == 1) begin
                run_no_clock(c);
            end else begin
                expect_result(c, sc == 2, 1'b1);
                issue(c);
                device_run(sc == 0, -1);
                wait_idle();
            end
        end

        repeat (10) @(negedge clock);
        check("expect_queue_drained", exp_q.size(), 0);
        check("capture_queue_drained", cap_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
